// File: rtl/div_ctrl.sv
// EX-stage controller for the iterative divider: issues DIV/DIVU, stalls the
// pipeline while the divide is outstanding, and commits quotient/remainder to HI/LO.
module div_ctrl #(
   parameter int MAX_CYCLES   = 40,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        flush_i,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_opa_o,
   output logic [31:0] div_opb_o,
   output logic        stall_req_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        timeout_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam int CNT_MAX = (MAX_CYCLES > DRAIN_CYCLES) ? MAX_CYCLES : DRAIN_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic [1:0]    state;
   logic [CW-1:0] counter;
   logic          timeout_q;
   logic          issue;

   // Handshake: div_start_o is held high for the whole BUSY period; the divider
   // answers with a single-cycle div_ready_i pulse. A ready outside BUSY is dropped.
   assign issue = (state == ST_IDLE) && div_req_i && !flush_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         counter      <= '0;
         div_opa_o    <= '0;
         div_opb_o    <= '0;
         div_signed_o <= 1'b0;
         hi_o         <= '0;
         lo_o         <= '0;
         timeout_q    <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  div_opa_o    <= op_a_i;
                  div_opb_o    <= op_b_i;
                  div_signed_o <= div_signed_i;
                  counter      <= '0;
                  state        <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               counter <= counter + 1'b1;
               // Flush beats a same-cycle ready: the killed instruction must not write HI/LO.
               if (flush_i) begin
                  counter <= '0;
                  state   <= ST_DRAIN;
               end else if (div_ready_i) begin
                  hi_o  <= div_result_i[63:32];
                  lo_o  <= div_result_i[31:0];
                  state <= ST_DONE;
               end else if (counter == CW'(MAX_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  counter   <= '0;
                  state     <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            ST_DRAIN: begin
               counter <= counter + 1'b1;
               if (counter == CW'(DRAIN_CYCLES - 1)) begin
                  counter <= '0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign div_start_o = (state == ST_BUSY);
   assign div_annul_o = (state == ST_DRAIN);
   assign hilo_we_o   = (state == ST_DONE);
   assign stall_req_o = (state == ST_BUSY) || (state == ST_DRAIN) || issue;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed and randomized divides against a behavioural
// divider and an arithmetic reference of the expected HI/LO and cycle timeline.
module tb_div_ctrl;

   localparam int MAXC  = 40;
   localparam int DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_req_i, div_signed_i, flush_i, div_ready_i;
   logic [31:0] op_a_i, op_b_i;
   logic [63:0] div_result_i;
   logic        div_start_o, div_annul_o, div_signed_o, stall_req_o, hilo_we_o, timeout_o;
   logic [31:0] div_opa_o, div_opb_o, hi_o, lo_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_hi, last_lo;

   div_ctrl #(.MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst),
      .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i),
      .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .stall_req_o(stall_req_o),
      .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Reference divide: truncating division, by-zero gives 0/0, result {rem, quo}.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // One divide, issued on a negedge with the DUT in IDLE. lat: BUSY cycle in which
   // the divider pulses ready (0 = never). fl: BUSY cycle carrying flush (0 = none).
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int lat, input int fl, input bit keep_req, input bit drain_ready);
      int          t_end;
      bit          done_path, to_path;
      logic [63:0] exp;
      logic [4:0]  ev;
      exp = ref_div(a, b, sgn);
      if (fl != 0 && (lat == 0 || fl <= lat) && fl <= MAXC) begin
         t_end = fl; done_path = 1'b0; to_path = 1'b0;
      end else if (lat != 0 && lat <= MAXC) begin
         t_end = lat; done_path = 1'b1; to_path = 1'b0;
      end else begin
         t_end = MAXC; done_path = 1'b0; to_path = 1'b1;
      end

      div_req_i = 1'b1; div_signed_i = sgn; op_a_i = a; op_b_i = b;
      flush_i = 1'b0; div_ready_i = 1'b0;
      #1;
      checks++;
      if (stall_req_o !== 1'b1 || div_start_o !== 1'b0 || hilo_we_o !== 1'b0 || div_annul_o !== 1'b0) begin
         errors++;
         $display("FAIL issue stall=%b start=%b we=%b annul=%b exp 1 0 0 0",
                  stall_req_o, div_start_o, hilo_we_o, div_annul_o);
      end
      @(negedge clk);

      for (int c = 1; c <= t_end; c++) begin
         checks++;
         if ({div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o} !== 5'b11000) begin
            errors++;
            $display("FAIL busy_ctl cyc=%0d got=%b exp=11000", c,
                     {div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o});
         end
         checks++;
         if (div_opa_o !== a || div_opb_o !== b || div_signed_o !== sgn) begin
            errors++;
            $display("FAIL busy_ops cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c,
                     div_opa_o, div_opb_o, div_signed_o, a, b, sgn);
         end
         op_a_i = $urandom; op_b_i = $urandom; div_signed_i = 1'($urandom_range(0, 1));
         flush_i = (c == fl);
         div_ready_i = (c == lat);
         if (div_ready_i) div_result_i = ref_div(div_opa_o, div_opb_o, div_signed_o);
         else div_result_i = {$urandom, $urandom};
         @(negedge clk);
      end
      div_ready_i = 1'b0; flush_i = 1'b0;

      if (done_path) begin
         checks++;
         if ({div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o} !== 5'b00010) begin
            errors++;
            $display("FAIL done_ctl got=%b exp=00010",
                     {div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o});
         end
         checks++;
         if (hi_o !== exp[63:32] || lo_o !== exp[31:0]) begin
            errors++;
            $display("FAIL done_hilo got=%h/%h exp=%h/%h", hi_o, lo_o, exp[63:32], exp[31:0]);
         end
         last_hi = exp[63:32]; last_lo = exp[31:0];
         if (!keep_req) div_req_i = 1'b0;
         @(negedge clk);
         checks++;
         if (hilo_we_o !== 1'b0 || div_start_o !== 1'b0 || stall_req_o !== keep_req) begin
            errors++;
            $display("FAIL post_done we=%b start=%b stall=%b exp 0 0 %b",
                     hilo_we_o, div_start_o, stall_req_o, keep_req);
         end
      end else begin
         div_req_i = 1'b0;
         for (int d = 1; d <= DRAIN; d++) begin
            ev = {1'b0, 1'b1, 1'b1, 1'b0, (to_path && d == 1)};
            checks++;
            if ({div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o} !== ev) begin
               errors++;
               $display("FAIL drain_ctl d=%0d got=%b exp=%b", d,
                        {div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o}, ev);
            end
            div_ready_i = drain_ready && (d == 1);
            div_result_i = {$urandom, $urandom};
            @(negedge clk);
         end
         div_ready_i = 1'b0;
         checks++;
         if ({div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o} !== 5'b00000) begin
            errors++;
            $display("FAIL drain_exit got=%b exp=00000",
                     {div_start_o, stall_req_o, div_annul_o, hilo_we_o, timeout_o});
         end
      end
      checks++;
      if (hi_o !== last_hi || lo_o !== last_lo) begin
         errors++;
         $display("FAIL hilo_hold got=%h/%h exp=%h/%h", hi_o, lo_o, last_hi, last_lo);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; div_req_i = 1'b0; div_signed_i = 1'b0; op_a_i = '0; op_b_i = '0;
      flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
      last_hi = '0; last_lo = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({div_start_o, div_annul_o, div_signed_o, stall_req_o, hilo_we_o, timeout_o} !== 6'b0 ||
          div_opa_o !== '0 || div_opb_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
         errors++;
         $display("FAIL reset ctl=%b opa=%h opb=%h hi=%h lo=%h exp all 0",
                  {div_start_o, div_annul_o, div_signed_o, stall_req_o, hilo_we_o, timeout_o},
                  div_opa_o, div_opb_o, hi_o, lo_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_divu_basic();
      do_div(32'd100, 32'd7, 1'b0, 34, 0, 1'b0, 1'b0);
      checks++;
      if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
         errors++;
         $display("FAIL divu_100_7 got=%0d/%0d exp=2/14", hi_o, lo_o);
      end
   endtask

   task automatic test_div_signed();
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 34, 0, 1'b0, 1'b0);
      checks++;
      if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_m7_2 got=%h/%h exp=ffffffff/fffffffd", hi_o, lo_o);
      end
   endtask

   task automatic test_div_by_zero();
      do_div(32'd5, 32'd0, 1'b0, 35, 0, 1'b0, 1'b0);
      checks++;
      if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
         errors++;
         $display("FAIL divu_5_0 got=%h/%h exp=0/0", hi_o, lo_o);
      end
   endtask

   task automatic test_flush();
      do_div(32'd1000, 32'd10, 1'b0, 20, 10, 1'b0, 1'b1);
      do_div(32'd9, 32'd3, 1'b0, 34, 0, 1'b0, 1'b0);
      checks++;
      if (hi_o !== 32'd0 || lo_o !== 32'd3) begin
         errors++;
         $display("FAIL divu_9_3 got=%0d/%0d exp=0/3", hi_o, lo_o);
      end
   endtask

   task automatic test_timeout();
      do_div(32'd77, 32'd5, 1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_flush_ready_same_cycle();
      do_div(32'd64, 32'd8, 1'b0, 12, 12, 1'b0, 1'b0);
   endtask

   task automatic test_ready_at_limit();
      do_div(32'd123456, 32'd321, 1'b0, MAXC, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_div(32'd50, 32'd6, 1'b0, 34, 0, 1'b1, 1'b0);
      do_div(32'hFFFF_FF00, 32'd7, 1'b1, 34, 0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      div_req_i = 1'b1; div_signed_i = 1'b1; op_a_i = 32'h1234_5678; op_b_i = 32'h0000_0033;
      @(negedge clk);
      repeat (5) @(negedge clk);
      div_req_i = 1'b0;
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({div_start_o, div_annul_o, div_signed_o, stall_req_o, hilo_we_o, timeout_o} !== 6'b0 ||
          div_opa_o !== '0 || div_opb_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
         errors++;
         $display("FAIL async_reset ctl=%b opa=%h opb=%h hi=%h lo=%h exp all 0",
                  {div_start_o, div_annul_o, div_signed_o, stall_req_o, hilo_we_o, timeout_o},
                  div_opa_o, div_opb_o, hi_o, lo_o);
      end
      @(negedge clk);
      rst = 1'b0;
      last_hi = '0; last_lo = '0;
      do_div(32'd8, 32'd2, 1'b0, 34, 0, 1'b0, 1'b0);
      checks++;
      if (hi_o !== 32'd0 || lo_o !== 32'd4) begin
         errors++;
         $display("FAIL divu_8_2 got=%0d/%0d exp=0/4", hi_o, lo_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int          lat, fl;
      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = {{16{1'b1}}, 16'($urandom)};
            default: b = $urandom;
         endcase
         lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXC + 2);
         fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAXC) : 0;
         do_div(a, b, 1'($urandom_range(0, 1)), lat, fl,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_div_signed();
      test_div_by_zero();
      test_flush();
      test_timeout();
      test_flush_ready_same_cycle();
      test_ready_at_limit();
      test_back_to_back();
      test_async_reset();
      test_random();
      div_req_i = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- EX-stage initiator for the iterative divider: issues DIV/DIVU operations, stalls the pipeline until the divider reports a result, then commits quotient and remainder to HI/LO.
- Drives the divider's start/annul/signed/operand inputs and consumes its 64-bit result and one-cycle ready pulse.
- Handles pipeline flush mid-divide and guards against a hung divider with a timeout.

Parameters:
- MAX_CYCLES, 40, BUSY cycles allowed before timeout (divider nominal: 1 setup + 32 iterations + 1 fixup + 1 end).
- DRAIN_CYCLES, 3, cycles annul is held and ready is ignored after a cancel or timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- div_req_i  in  1  the EX instruction is DIV/DIVU.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- op_a_i  in  32  dividend (rs).
- op_b_i  in  32  divisor (rt).
- flush_i  in  1  kill the EX instruction (exception/eret).
- div_result_i  in  64  from divider: {remainder[63:32], quotient[31:0]}.
- div_ready_i  in  1  from divider: one-cycle result-valid pulse.
- div_start_o  out  1  to divider: start request.
- div_annul_o  out  1  to divider: cancel request.
- div_signed_o  out  1  to divider: registered signed flag.
- div_opa_o  out  32  to divider: registered dividend.
- div_opb_o  out  32  to divider: registered divisor.
- stall_req_o  out  1  hold IF/ID/EX while a divide is outstanding.
- hilo_we_o  out  1  one-cycle HI/LO write enable.
- hi_o  out  32  remainder to HI.
- lo_o  out  32  quotient to LO.
- timeout_o  out  1  one-cycle pulse when MAX_CYCLES is exceeded.

Behaviour:
- Reset (async, any state): state = IDLE, counter = 0, and every output is 0.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - If div_req_i=1 and flush_i=0: latch op_a_i, op_b_i and div_signed_i into the div_op*/div_signed_o registers. Set div_start_o=1, stall_req_o=1, counter=0, then go to BUSY.
  - Otherwise all strobes are 0 and stall_req_o=0.
  - Combinational stall: stall_req_o is also asserted combinationally when state=IDLE, div_req_i=1 and flush_i=0, so the issuing instruction never advances.
- BUSY:
  - div_start_o=1, stall_req_o=1. The div_op*/div_signed_o registers stay frozen: the divider rereads the operand signs at fixup, so they must not change until ready.
  - Counter increments every cycle.
  - div_ready_i=1: capture hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0]; hilo_we_o=1 next cycle; div_start_o=0; go to DONE.
  - flush_i=1 (takes priority over ready in the same cycle): div_start_o=0, div_annul_o=1, no HI/LO write, counter=0, go to DRAIN.
  - Counter reaches MAX_CYCLES without ready: pulse timeout_o, div_annul_o=1, counter=0, go to DRAIN. HI/LO are not written.
- DONE (exactly 1 cycle):
  - hilo_we_o=1, stall_req_o=0, div_start_o=0.
  - The instruction leaves EX at the end of this cycle, then go to IDLE.
  - A div_req_i seen during DONE is ignored; it is the same instruction.
- DRAIN:
  - div_annul_o=1, div_start_o=0, stall_req_o=1.
  - div_ready_i is ignored. This covers a divider caught in its by-zero/end path, which still emits a ready pulse.
  - After DRAIN_CYCLES cycles: annul=0, go to IDLE.
- Divide by zero: the divider returns 0/0; the controller commits HI=0, LO=0 with no special casing.
- Back-to-back divides: the second issue occurs in IDLE the cycle after DONE. Minimum gap between start assertions is 2 cycles, which guarantees the divider has returned to free.
- hi_o/lo_o hold their last captured value between writes.

Test Plan:
- DIVU 100/7 → start held until ready; hilo_we_o pulses once; HI=2, LO=14; stall_req_o low in the DONE cycle only.
- DIV signed 0xFFFFFFF9(-7)/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD; div_op* stable for the entire BUSY period.
- DIVU 5/0 → HI=0, LO=0, hilo_we_o=1 once; no timeout.
- flush_i asserted 10 cycles into BUSY → annul high for 3 cycles, no hilo_we_o, any ready pulse ignored; a new DIVU 9/3 afterwards yields LO=3, HI=0.
- Divider model never returns ready → timeout_o pulse after 40 BUSY cycles, DRAIN, then back to IDLE with stall_req_o=0.
- rst asserted mid-BUSY (async, between edges) → all outputs 0 immediately; after release the next DIVU 8/2 gives LO=4, HI=0.
